// File: rtl/awg_sequence_scheduler_if.sv
// awg_sequence_scheduler_if: table-write, playback-control and step-output
// bundle between input processing (master) and the step sequencer (slave).
// Optional: AWG_SEQ_ERR_EN adds the sticky err flag.
interface awg_sequence_scheduler_if #(
  parameter int ADDR_W = 3
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_wave;
  logic [19:0]       wr_freq;
  logic [15:0]       wr_dwell;
  logic              wr_ready;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W:0]   num_steps;
  logic [19:0]       freq_out;
  logic [1:0]        wave_sel;
  logic [ADDR_W-1:0] step_idx;
  logic              step_strobe;
  logic              seq_active;
  logic              done;
`ifdef AWG_SEQ_ERR_EN
  logic              err;
`endif

  modport master (
    output wr_en, wr_addr, wr_wave, wr_freq, wr_dwell,
    output start, stop, loop_en, num_steps,
    input  wr_ready, freq_out, wave_sel, step_idx, step_strobe, seq_active, done
`ifdef AWG_SEQ_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  wr_en, wr_addr, wr_wave, wr_freq, wr_dwell,
    input  start, stop, loop_en, num_steps,
    output wr_ready, freq_out, wave_sel, step_idx, step_strobe, seq_active, done
`ifdef AWG_SEQ_ERR_EN
    , output err
`endif
  );
endinterface

// File: rtl/awg_sequence_scheduler.sv
// awg_sequence_scheduler: plays a small table of {wave, freq, dwell_ms} steps,
// driving the sweep base frequency and the wave-mux select.
// Optional: define AWG_SEQ_ERR_EN to add the sticky err output.
// MS_TICKS must be at least 2.
module awg_sequence_scheduler #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int MS_TICKS = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  awg_sequence_scheduler_if.slave bus
);

  localparam int PRESC_W = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(MS_TICKS - 1);
  localparam logic [PRESC_W-1:0] PRESC_PEN  = PRESC_W'(MS_TICKS - 2);
  localparam logic [ADDR_W:0]    DEPTH_N    = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DWELL = 2'd2
  } state_t;

  // step table
  logic [1:0]  tbl_wave_r  [DEPTH];
  logic [19:0] tbl_freq_r  [DEPTH];
  logic [15:0] tbl_dwell_r [DEPTH];

  // sequencer state and registered outputs
  state_t            state_r,     state_s;
  logic [ADDR_W-1:0] idx_r,       idx_s;
  logic [ADDR_W:0]   num_r,       num_s;
  logic [15:0]       dwell_cnt_r, dwell_cnt_s;
  logic [PRESC_W-1:0] presc_r,    presc_s;
  logic [19:0]       freq_r,      freq_s;
  logic [1:0]        wave_r,      wave_s;
  logic [ADDR_W-1:0] step_idx_r,  step_idx_s;
  logic              strobe_r,    strobe_s;
  logic              active_r,    active_s;
  logic              done_r,      done_s;
  logic              ready_r,     ready_s;

  logic              num_ok_s;
  logic              accept_s;
  logic              addr_ok_s;
  logic              wr_ok_s;
  logic              last_s;
  logic              step_end_s;
  logic              seq_end_s;
  logic [15:0]       ld_dwell_s;

  assign num_ok_s   = (bus.num_steps != {(ADDR_W + 1){1'b0}}) && (bus.num_steps <= DEPTH_N);
  assign accept_s   = (state_r == ST_IDLE) && bus.start && !bus.stop && num_ok_s;
  assign addr_ok_s  = ({1'b0, bus.wr_addr} < DEPTH_N);
  assign wr_ok_s    = bus.wr_en && ready_r && addr_ok_s;
  assign last_s     = ({1'b0, idx_r} == (num_r - {{ADDR_W{1'b0}}, 1'b1}));
  // The next LOAD cycle is part of the current step's period, so a step that
  // continues ends one tick early; a final step runs its full period so that
  // done lands where the next strobe would have.
  assign step_end_s = (dwell_cnt_r == 16'd1) && (presc_r == PRESC_PEN);
  assign seq_end_s  = (dwell_cnt_r == 16'd1) && (presc_r == PRESC_LAST);
  assign ld_dwell_s = tbl_dwell_r[idx_r];

  // Step-table write port; only accepted while the sequencer is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_wave_r[i]  <= 2'd0;
        tbl_freq_r[i]  <= 20'd0;
        tbl_dwell_r[i] <= 16'd0;
      end
    end else if (wr_ok_s) begin
      tbl_wave_r[bus.wr_addr]  <= bus.wr_wave;
      tbl_freq_r[bus.wr_addr]  <= bus.wr_freq;
      tbl_dwell_r[bus.wr_addr] <= bus.wr_dwell;
    end
  end

  // Next-state and next-output logic for the IDLE/LOAD/DWELL sequencer.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    num_s       = num_r;
    dwell_cnt_s = dwell_cnt_r;
    presc_s     = presc_r;
    freq_s      = freq_r;
    wave_s      = wave_r;
    step_idx_s  = step_idx_r;
    strobe_s    = 1'b0;
    active_s    = active_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_LOAD;
          idx_s   = {ADDR_W{1'b0}};
          num_s   = bus.num_steps;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.stop) begin
          state_s  = ST_IDLE;
          active_s = 1'b0;
        end else begin
          freq_s      = tbl_freq_r[idx_r];
          wave_s      = tbl_wave_r[idx_r];
          step_idx_s  = idx_r;
          strobe_s    = 1'b1;
          active_s    = 1'b1;
          dwell_cnt_s = (ld_dwell_s == 16'd0) ? 16'd1 : ld_dwell_s;
          presc_s     = {PRESC_W{1'b0}};
          state_s     = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (bus.stop) begin
          state_s  = ST_IDLE;
          active_s = 1'b0;
        end else begin
          if (presc_r == PRESC_LAST) begin
            presc_s     = {PRESC_W{1'b0}};
            dwell_cnt_s = dwell_cnt_r - 16'd1;
          end else begin
            presc_s = presc_r + PRESC_W'(1);
          end
          if (step_end_s && !(last_s && !bus.loop_en)) begin
            state_s = ST_LOAD;
            if (last_s) begin
              idx_s = {ADDR_W{1'b0}};
            end else begin
              idx_s = idx_r + ADDR_W'(1);
            end
          end else if (seq_end_s && last_s) begin
            state_s  = ST_IDLE;
            active_s = 1'b0;
            done_s   = 1'b1;
          end else begin
            state_s = ST_DWELL;
          end
        end
      end
      default: begin
        state_s  = ST_IDLE;
        active_s = 1'b0;
      end
    endcase
    ready_s = (state_s == ST_IDLE);
  end

  // Sequencer state register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= {ADDR_W{1'b0}};
      num_r       <= {(ADDR_W + 1){1'b0}};
      dwell_cnt_r <= 16'd0;
      presc_r     <= {PRESC_W{1'b0}};
      freq_r      <= 20'd0;
      wave_r      <= 2'd0;
      step_idx_r  <= {ADDR_W{1'b0}};
      strobe_r    <= 1'b0;
      active_r    <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      num_r       <= num_s;
      dwell_cnt_r <= dwell_cnt_s;
      presc_r     <= presc_s;
      freq_r      <= freq_s;
      wave_r      <= wave_s;
      step_idx_r  <= step_idx_s;
      strobe_r    <= strobe_s;
      active_r    <= active_s;
      done_r      <= done_s;
      ready_r     <= ready_s;
    end
  end

  assign bus.freq_out    = freq_r;
  assign bus.wave_sel    = wave_r;
  assign bus.step_idx    = step_idx_r;
  assign bus.step_strobe = strobe_r;
  assign bus.seq_active  = active_r;
  assign bus.done        = done_r;
  assign bus.wr_ready    = ready_r;

`ifdef AWG_SEQ_ERR_EN
  logic err_r;
  logic err_s;

  // Sticky request-error flag: rejected starts and writes set it, the next
  // accepted start clears it; a new error in the same cycle wins.
  assign err_s = (err_r && !accept_s)
               || (bus.wr_en && !ready_r)
               || (bus.wr_en && !addr_ok_s)
               || ((state_r == ST_IDLE) && bus.start && !bus.stop && !num_ok_s);

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_s;
    end
  end

  assign bus.err = err_r;
`endif

endmodule

// File: tb/tb_awg_sequence_scheduler.sv
// tb_awg_sequence_scheduler: directed, table-driven bench for the step
// sequencer with MS_TICKS = 10. Inputs change and outputs are sampled on the
// falling clock edge; event cycle k counts falling edges after start is driven.
module tb_awg_sequence_scheduler;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int MS_TICKS = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  awg_sequence_scheduler_if #(.ADDR_W(ADDR_W)) bus ();

  awg_sequence_scheduler #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MS_TICKS(MS_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  typedef struct {
    int          at;
    logic        is_done;
    logic [19:0] freq;
    logic [1:0]  wave;
    logic [2:0]  idx;
  } ev_t;

  typedef struct {
    logic [2:0]  addr;
    logic [1:0]  wave;
    logic [19:0] freq;
    logic [15:0] dwell;
  } wr_t;

  ev_t evq[$];
  wr_t wr_vec[3];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk(input int at, input logic d, input logic [19:0] f,
                             input logic [1:0] w, input logic [2:0] i);
    ev_t e;
    e.at = at; e.is_done = d; e.freq = f; e.wave = w; e.idx = i;
    return e;
  endfunction

  task automatic write_entry(input logic [2:0] a, input logic [1:0] w,
                             input logic [19:0] f, input logic [15:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_wave = w; bus.wr_freq = f; bus.wr_dwell = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Start a sequence and compare strobe/done/active every cycle against evq.
  task automatic run_seq(input logic [3:0] num, input logic lp, input int cycles,
                         input int stop_at, input int wr_at);
    logic act_exp;
    logic hit;
    ev_t  e;
    act_exp = 1'b0;
    @(negedge clk);
    bus.num_steps = num; bus.loop_en = lp; bus.start = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      if (k == stop_at + 1) begin
        bus.stop = 1'b0;
        act_exp = 1'b0;
      end
      hit = 1'b0;
      e = mk(0, 1'b0, 20'd0, 2'd0, 3'd0);
      foreach (evq[i]) begin
        if (evq[i].at == k) begin
          hit = 1'b1;
          e = evq[i];
        end
      end
      if (hit) act_exp = !e.is_done;
      check("step_strobe", {31'd0, bus.step_strobe}, {31'd0, hit && !e.is_done});
      check("done", {31'd0, bus.done}, {31'd0, hit && e.is_done});
      check("seq_active", {31'd0, bus.seq_active}, {31'd0, act_exp});
      if (hit && !e.is_done) begin
        check("freq_out", {12'd0, bus.freq_out}, {12'd0, e.freq});
        check("wave_sel", {30'd0, bus.wave_sel}, {30'd0, e.wave});
        check("step_idx", {29'd0, bus.step_idx}, {29'd0, e.idx});
      end
      if (k == stop_at) bus.stop = 1'b1;
      if (k == wr_at) begin
        check("wr_ready_busy", {31'd0, bus.wr_ready}, 32'd0);
        bus.wr_en = 1'b1; bus.wr_addr = 3'd1; bus.wr_wave = 2'd0;
        bus.wr_freq = 20'd7777; bus.wr_dwell = 16'd5;
      end
    end
  endtask

  task automatic load_base_events();
    evq.delete();
    evq.push_back(mk(2,  1'b0, 20'd1000,  2'd0, 3'd0));
    evq.push_back(mk(22, 1'b0, 20'd5000,  2'd1, 3'd1));
    evq.push_back(mk(32, 1'b0, 20'd20000, 2'd3, 3'd2));
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = 3'd0; bus.wr_wave = 2'd0; bus.wr_freq = 20'd0;
    bus.wr_dwell = 16'd0; bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0;
    bus.num_steps = 4'd0;

    wr_vec[0] = '{addr: 3'd0, wave: 2'd0, freq: 20'd1000,  dwell: 16'd2};
    wr_vec[1] = '{addr: 3'd1, wave: 2'd1, freq: 20'd5000,  dwell: 16'd1};
    wr_vec[2] = '{addr: 3'd2, wave: 2'd3, freq: 20'd20000, dwell: 16'd3};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_freq", {12'd0, bus.freq_out}, 32'd0);
    check("rst_wave", {30'd0, bus.wave_sel}, 32'd0);
    check("rst_idx", {29'd0, bus.step_idx}, 32'd0);
    check("rst_strobe", {31'd0, bus.step_strobe}, 32'd0);
    check("rst_active", {31'd0, bus.seq_active}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
`ifdef AWG_SEQ_ERR_EN
    check("rst_err", {31'd0, bus.err}, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) write_entry(wr_vec[i].addr, wr_vec[i].wave, wr_vec[i].freq, wr_vec[i].dwell);

    // one-shot playback of three steps
    load_base_events();
    evq.push_back(mk(62, 1'b1, 20'd0, 2'd0, 3'd0));
    run_seq(4'd3, 1'b0, 70, -1, -1);
    check("hold_freq", {12'd0, bus.freq_out}, 32'd20000);
    check("hold_wave", {30'd0, bus.wave_sel}, 32'd3);
    check("hold_idx", {29'd0, bus.step_idx}, 32'd2);
    check("idle_wr_ready", {31'd0, bus.wr_ready}, 32'd1);

    // looped playback, stop in the dwell of the second pass of step 1
    load_base_events();
    evq.push_back(mk(62, 1'b0, 20'd1000, 2'd0, 3'd0));
    evq.push_back(mk(82, 1'b0, 20'd5000, 2'd1, 3'd1));
    run_seq(4'd3, 1'b1, 100, 90, -1);
    check("stop_hold_freq", {12'd0, bus.freq_out}, 32'd5000);
    check("stop_hold_idx", {29'd0, bus.step_idx}, 32'd1);

    // zero dwell plays as one millisecond
    write_entry(3'd0, 2'd2, 20'd4242, 16'd0);
    evq.delete();
    evq.push_back(mk(2,  1'b0, 20'd4242, 2'd2, 3'd0));
    evq.push_back(mk(12, 1'b1, 20'd0, 2'd0, 3'd0));
    run_seq(4'd1, 1'b0, 16, -1, -1);
    write_entry(3'd0, 2'd0, 20'd1000, 16'd2);

    // write while active is ignored
    load_base_events();
    evq.push_back(mk(62, 1'b1, 20'd0, 2'd0, 3'd0));
    run_seq(4'd3, 1'b0, 66, -1, 40);
`ifdef AWG_SEQ_ERR_EN
    check("err_busy_write", {31'd0, bus.err}, 32'd1);
`endif
    run_seq(4'd3, 1'b0, 66, -1, -1);
`ifdef AWG_SEQ_ERR_EN
    check("err_cleared", {31'd0, bus.err}, 32'd0);
`endif

    // invalid step counts and start+stop collision
    evq.delete();
    run_seq(4'd0, 1'b0, 8, -1, -1);
`ifdef AWG_SEQ_ERR_EN
    check("err_num0", {31'd0, bus.err}, 32'd1);
`endif
    run_seq(4'd9, 1'b0, 8, -1, -1);
    @(negedge clk);
    bus.num_steps = 4'd3; bus.start = 1'b1; bus.stop = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.stop = 1'b0;
      check("startstop_active", {31'd0, bus.seq_active}, 32'd0);
      check("startstop_strobe", {31'd0, bus.step_strobe}, 32'd0);
    end

    // asynchronous reset in the middle of a dwell
    load_base_events();
    run_seq(4'd3, 1'b0, 10, -1, -1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_freq", {12'd0, bus.freq_out}, 32'd0);
    check("arst_wave", {30'd0, bus.wave_sel}, 32'd0);
    check("arst_active", {31'd0, bus.seq_active}, 32'd0);
    check("arst_wr_ready", {31'd0, bus.wr_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    evq.delete();
    evq.push_back(mk(2,  1'b0, 20'd0, 2'd0, 3'd0));
    evq.push_back(mk(12, 1'b0, 20'd0, 2'd0, 3'd1));
    evq.push_back(mk(22, 1'b0, 20'd0, 2'd0, 3'd2));
    evq.push_back(mk(32, 1'b1, 20'd0, 2'd0, 3'd0));
    run_seq(4'd3, 1'b0, 36, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
